// File: rtl/tick_generator.sv
// tick_generator: N_CH independent tick-enable channels derived from clk.
// Each channel divides clk by a run-time programmable divisor, producing a
// one-cycle tick per period. A new divisor is held pending and only takes
// over at a period boundary, a disable or a restart, so periods never glitch.
// Optional feature: define TICKGEN_SQ_EN to add the 50%-duty sq outputs that
// toggle on every tick; without it the block is tick-only.
module tick_generator #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 25000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             restart,
  input  logic             wr_en,
  input  logic [3:0]       wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  output logic [N_CH-1:0]  tick
`ifdef TICKGEN_SQ_EN
  ,
  output logic [N_CH-1:0]  sq
`endif
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t RESET_DIV = cnt_t'(DEFAULT_DIV);

  // Per-channel state
  cnt_t            cnt_q   [N_CH];
  cnt_t            cnt_d   [N_CH];
  cnt_t            div_a_q [N_CH];
  cnt_t            div_a_d [N_CH];
  cnt_t            div_p_q [N_CH];
  cnt_t            div_p_d [N_CH];
  logic [N_CH-1:0] pend_q;
  logic [N_CH-1:0] pend_d;
  logic [N_CH-1:0] tick_q;
  logic [N_CH-1:0] tick_d;
`ifdef TICKGEN_SQ_EN
  logic [N_CH-1:0] sq_q;
  logic [N_CH-1:0] sq_d;
`endif

  // Per-channel helpers
  cnt_t            term    [N_CH];  // terminal count d-1, with d = max(div_a, 1)
  cnt_t            pend_val[N_CH];  // pending divisor including a same-cycle write
  logic [N_CH-1:0] wr_hit;
  logic [N_CH-1:0] pend_any;
  logic [N_CH-1:0] wrap;
  logic [N_CH-1:0] upd_pt;

  // Next-state logic for every channel: counting, wrap, disable, restart and
  // the pending-divisor handover.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      // NOTE: every variable gets a default at the top of the block so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      cnt_d[i]    = cnt_q[i];
      div_a_d[i]  = div_a_q[i];
      tick_d[i]   = 1'b0;
`ifdef TICKGEN_SQ_EN
      sq_d[i]     = sq_q[i];
`endif

      // Matching the index against i also rejects wr_ch >= N_CH.
      wr_hit[i]   = wr_en && (int'(wr_ch) == i);
      pend_val[i] = wr_hit[i] ? wr_div : div_p_q[i];
      pend_any[i] = wr_hit[i] | pend_q[i];
      div_p_d[i]  = pend_val[i];
      pend_d[i]   = pend_any[i];

      term[i]     = (div_a_q[i] == '0) ? '0 : div_a_q[i] - cnt_t'(1);
      wrap[i]     = (cnt_q[i] == term[i]);
      upd_pt[i]   = restart | ~en[i] | wrap[i];

      if (restart || !en[i]) begin
        cnt_d[i]  = '0;
`ifdef TICKGEN_SQ_EN
        sq_d[i]   = 1'b0;
`endif
      end else if (wrap[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
`ifdef TICKGEN_SQ_EN
        sq_d[i]   = ~sq_q[i];
`endif
      end else begin
        cnt_d[i]  = cnt_q[i] + cnt_t'(1);
      end

      // The wrap test above used the old divisor, so the running period
      // finishes before the new one takes over.
      if (upd_pt[i] && pend_any[i]) begin
        div_a_d[i] = pend_val[i];
        pend_d[i]  = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset to the default divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-channel arrays are flops, not RAM, and they hold the
      // divisors the outputs depend on, so every entry is reset explicitly.
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= '0;
        div_a_q[i] <= RESET_DIV;
        div_p_q[i] <= RESET_DIV;
      end
      pend_q <= '0;
      tick_q <= '0;
`ifdef TICKGEN_SQ_EN
      sq_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before the edge, independent of statement order.
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        div_a_q[i] <= div_a_d[i];
        div_p_q[i] <= div_p_d[i];
      end
      pend_q <= pend_d;
      tick_q <= tick_d;
`ifdef TICKGEN_SQ_EN
      sq_q   <= sq_d;
`endif
    end
  end

  assign tick = tick_q;
`ifdef TICKGEN_SQ_EN
  assign sq   = sq_q;
`endif

endmodule
